unidade_controle: RTL and testbench
===================================

UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 Parameter DATA_W, default 16, width of DIN; the IR is taken from DIN[DATA_W-1:DATA_W-9].
REQ-002 Clock  input  1  single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  reset, synchronous, active-high.
REQ-004 Run  input  1  start request, sampled only in step T0.
REQ-005 DIN  input  DATA_W  instruction/data bus; IR field is III XXX YYY.
REQ-006 Gnz  input  1  datapath flag, high when register G is nonzero.
REQ-007 IRin  output  1  IR load strobe, visible to the datapath.
REQ-008 Rout  output  8  one-hot register-to-bus select.
REQ-009 Rin  output  8  one-hot register load enables.
REQ-010 Ain, Gin, Gout, DINout, AddSub  output  1 each  datapath controls; AddSub high selects subtract.
REQ-011 Done  output  1  high in the final step of an instruction.
REQ-012 Tstep  output  2  current step, T0=00 through T3=11.

Function
REQ-013 The block SHALL own a 9-bit IR register, loaded from the DIN IR field on the edge ending any T0 cycle with Run=1.
REQ-014 In T0 the block SHALL drive IRin=Run; if Run=0, Tstep SHALL hold at T0.
REQ-015 The step SHALL advance T0->T1->T2->T3 one per cycle, and SHALL return to T0 on the edge ending any cycle with Done=1.
REQ-016 All control outputs SHALL be combinational decodes of (Tstep, IR), with zero added latency; any output not named for a step SHALL be 0.
REQ-017 mv (000), T1: Rout[Y]=1, Rin[X]=1, Done=1.
REQ-018 mvi (001), T1: DINout=1, Rin[X]=1, Done=1.
REQ-019 add (010) / sub (011):
- T1: Rout[X]=1, Ain=1.
- T2: Rout[Y]=1, Gin=1, AddSub=1 for sub only.
- T3: Gout=1, Rin[X]=1, Done=1.
REQ-020 Opcodes 101, 110 and 111 SHALL execute as NOP: Done=1 in T1, no other control asserted.
REQ-021 Run changes after T0 SHALL NOT affect an instruction in progress.
REQ-022 With Run held high, the next IR fetch SHALL occur in the T0 cycle immediately after Done, with no idle cycle.
REQ-023 Rout and Rin SHALL each have at most one bit set in any cycle.

Reset
REQ-024 On a cycle with Reset=1, the next state SHALL be Tstep=T0 and IR=0, overriding Run and any instruction in progress, including mid-instruction (T1..T3).
REQ-025 While Reset=1, IRin and every other control output SHALL be 0.

Configuration
REQ-026 Macro CTRL_MVNZ_EN:
- Defined: opcode 100 is mvnz. T1 drives Rout[Y]=1 and Done=1; Rin[X]=Gnz.
- Undefined: opcode 100 is a NOP per REQ-020, and Gnz is ignored.

Structure
REQ-027 Shared package processador_pkg SHALL hold:
- the opcode constants (OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_MVNZ);
- the step constants T0..T3;
- a 3-to-8 one-hot decode function.
REQ-028 The step counter SHALL be the sub-module contador_passo, with inputs Clock, Reset, Clear (=Done), Hold (=T0 and !Run), and output Tstep.

Verification
REQ-029 Reset pulse during T2 of add -> next cycle Tstep=00, all controls 0; a later Run re-fetches normally.
REQ-030 Run=1, DIN IR=001 010 000, then DIN=0x0005 -> T1: DINout=1, Rin=00000100, Done=1; next cycle Tstep=00.
REQ-031 IR=011 001 010 (sub R1,R2) ->
- T1: Rout=00000010, Ain=1.
- T2: Rout=00000100, Gin=1, AddSub=1.
- T3: Gout=1, Rin=00000010, Done=1.
REQ-032 Run held high over mv R3,R4 then add R0,R1 -> IRin=1 in cycles 0 and 2; Done in cycles 1 and 5.
REQ-033 Run=0 for 10 cycles -> Tstep stays 00 and IRin=0 throughout.
REQ-034 Opcode 100 XXX=5 YYY=6 with Gnz=0 and then Gnz=1, under CTRL_MVNZ_EN ->
- Rout=01000000 both times.
- Rin=00000000, then 00100000.
- Without the macro: NOP, Done at T1, no Rout/Rin.

Source files
------------

// File: rtl/processador_pkg.sv
// rtl/processador_pkg.sv - opcode/step constants and one-hot decode shared by the control unit
package processador_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MVNZ = 3'b100;

    localparam logic [1:0] T0 = 2'b00;
    localparam logic [1:0] T1 = 2'b01;
    localparam logic [1:0] T2 = 2'b10;
    localparam logic [1:0] T3 = 2'b11;

    function automatic logic [7:0] dec3to8(input logic [2:0] sel);
        logic [7:0] onehot;
        onehot = 8'b0000_0001 << sel;
        return onehot;
    endfunction

endpackage

// File: rtl/contador_passo.sv
// rtl/contador_passo.sv - two-bit instruction step counter with clear and hold
module contador_passo
    import processador_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Clear,
    input  logic       Hold,
    output logic [1:0] Tstep
);

    logic [1:0] step_next;

    always_comb begin
        step_next = Tstep;
        if (Clear) begin
            step_next = T0;
        end else if (!Hold) begin
            step_next = Tstep + 2'd1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Tstep <= T0;
        end else begin
            Tstep <= step_next;
        end
    end

endmodule

// File: rtl/unidade_controle.sv
// rtl/unidade_controle.sv - multi-cycle processor control unit; CTRL_MVNZ_EN enables mvnz on opcode 100
module unidade_controle
    import processador_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    input  logic              Gnz,
    output logic              IRin,
    output logic [7:0]        Rout,
    output logic [7:0]        Rin,
    output logic              Ain,
    output logic              Gin,
    output logic              Gout,
    output logic              DINout,
    output logic              AddSub,
    output logic              Done,
    output logic [1:0]        Tstep
);

    logic [8:0] ir;
    logic [2:0] op;
    logic [2:0] rx;
    logic [2:0] ry;
    logic       hold;

    assign op = ir[8:6];
    assign rx = ir[5:3];
    assign ry = ir[2:0];

    // Only the IR field of DIN matters here; the low bits are data for the datapath.
    logic unused_din;
`ifdef CTRL_MVNZ_EN
    assign unused_din = &{1'b0, DIN[DATA_W-10:0]};
`else
    assign unused_din = &{1'b0, DIN[DATA_W-10:0], Gnz};
`endif

    assign hold = (Tstep == T0) && !Run;

    contador_passo u_contador_passo (
        .Clock (Clock),
        .Reset (Reset),
        .Clear (Done),
        .Hold  (hold),
        .Tstep (Tstep)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ir <= 9'd0;
        end else if ((Tstep == T0) && Run) begin
            ir <= DIN[DATA_W-1 -: 9];
        end
    end

    // Pure decode of (step, IR); reset forces every control low.
    always_comb begin
        IRin   = 1'b0;
        Rout   = 8'd0;
        Rin    = 8'd0;
        Ain    = 1'b0;
        Gin    = 1'b0;
        Gout   = 1'b0;
        DINout = 1'b0;
        AddSub = 1'b0;
        Done   = 1'b0;
        if (!Reset) begin
            case (Tstep)
                T0: begin
                    IRin = Run;
                end
                T1: begin
                    case (op)
                        OP_MV: begin
                            Rout = dec3to8(ry);
                            Rin  = dec3to8(rx);
                            Done = 1'b1;
                        end
                        OP_MVI: begin
                            DINout = 1'b1;
                            Rin    = dec3to8(rx);
                            Done   = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            Rout = dec3to8(rx);
                            Ain  = 1'b1;
                        end
`ifdef CTRL_MVNZ_EN
                        OP_MVNZ: begin
                            Rout = dec3to8(ry);
                            Rin  = Gnz ? dec3to8(rx) : 8'd0;
                            Done = 1'b1;
                        end
`endif
                        default: begin
                            Done = 1'b1;
                        end
                    endcase
                end
                T2: begin
                    if ((op == OP_ADD) || (op == OP_SUB)) begin
                        Rout   = dec3to8(ry);
                        Gin    = 1'b1;
                        AddSub = (op == OP_SUB);
                    end
                end
                default: begin
                    if ((op == OP_ADD) || (op == OP_SUB)) begin
                        Gout = 1'b1;
                        Rin  = dec3to8(rx);
                        Done = 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unidade_controle.sv
// tb/tb_unidade_controle.sv - directed-vector bench for unidade_controle
module tb_unidade_controle;

    logic        Clock;
    logic        Reset;
    logic        Run;
    logic [15:0] DIN;
    logic        Gnz;
    logic        IRin;
    logic [7:0]  Rout;
    logic [7:0]  Rin;
    logic        Ain;
    logic        Gin;
    logic        Gout;
    logic        DINout;
    logic        AddSub;
    logic        Done;
    logic [1:0]  Tstep;

    int total;
    int bad;

    unidade_controle #(.DATA_W(16)) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .Run    (Run),
        .DIN    (DIN),
        .Gnz    (Gnz),
        .IRin   (IRin),
        .Rout   (Rout),
        .Rin    (Rin),
        .Ain    (Ain),
        .Gin    (Gin),
        .Gout   (Gout),
        .DINout (DINout),
        .AddSub (AddSub),
        .Done   (Done),
        .Tstep  (Tstep)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

`ifdef CTRL_MVNZ_EN
    localparam logic [7:0] MVNZ_ROUT    = 8'b0100_0000;
    localparam logic [7:0] MVNZ_RIN_GNZ = 8'b0010_0000;
`else
    localparam logic [7:0] MVNZ_ROUT    = 8'b0000_0000;
    localparam logic [7:0] MVNZ_RIN_GNZ = 8'b0000_0000;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // ctl order: {IRin, Ain, Gin, Gout, DINout, AddSub, Done}
    task automatic expect_all(input string tag, input logic [1:0] t, input logic [7:0] ro,
                              input logic [7:0] ri, input logic [6:0] ctl);
        #2;
        check({tag, ".tstep"}, 32'(Tstep), 32'(t));
        check({tag, ".rout"}, 32'(Rout), 32'(ro));
        check({tag, ".rin"}, 32'(Rin), 32'(ri));
        check({tag, ".ctl"}, 32'({IRin, Ain, Gin, Gout, DINout, AddSub, Done}), 32'(ctl));
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        Reset = 1'b1;
        Run   = 1'b1;
        DIN   = 16'hFFFF;
        Gnz   = 1'b0;
        tick;
        expect_all("rst", 2'd0, 8'h00, 8'h00, 7'b0000000);
        tick;
        expect_all("rst2", 2'd0, 8'h00, 8'h00, 7'b0000000);

        Reset = 1'b0;
        Run   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            expect_all("idle", 2'd0, 8'h00, 8'h00, 7'b0000000);
            tick;
        end

        // mvi R2, #5
        Run = 1'b1;
        DIN = {9'b001_010_000, 7'd0};
        expect_all("mvi_t0", 2'd0, 8'h00, 8'h00, 7'b1000000);
        tick;
        Run = 1'b0;
        DIN = 16'h0005;
        expect_all("mvi_t1", 2'd1, 8'h00, 8'b0000_0100, 7'b0000101);
        tick;
        expect_all("mvi_end", 2'd0, 8'h00, 8'h00, 7'b0000000);

        // sub R1, R2 with Run toggled mid-instruction
        Run = 1'b1;
        DIN = {9'b011_001_010, 7'd0};
        expect_all("sub_t0", 2'd0, 8'h00, 8'h00, 7'b1000000);
        tick;
        Run = 1'b0;
        DIN = 16'h0000;
        expect_all("sub_t1", 2'd1, 8'b0000_0010, 8'h00, 7'b0100000);
        tick;
        Run = 1'b1;
        expect_all("sub_t2", 2'd2, 8'b0000_0100, 8'h00, 7'b0010010);
        tick;
        Run = 1'b0;
        expect_all("sub_t3", 2'd3, 8'h00, 8'b0000_0010, 7'b0001001);
        tick;
        expect_all("sub_end", 2'd0, 8'h00, 8'h00, 7'b0000000);

        // back-to-back mv R3,R4 then add R0,R1 with Run held high
        Run = 1'b1;
        DIN = {9'b000_011_100, 7'd0};
        expect_all("b2b_c0", 2'd0, 8'h00, 8'h00, 7'b1000000);
        tick;
        DIN = {9'b010_000_001, 7'd0};
        expect_all("b2b_c1", 2'd1, 8'b0001_0000, 8'b0000_1000, 7'b0000001);
        tick;
        expect_all("b2b_c2", 2'd0, 8'h00, 8'h00, 7'b1000000);
        tick;
        DIN = 16'h0000;
        expect_all("b2b_c3", 2'd1, 8'b0000_0001, 8'h00, 7'b0100000);
        tick;
        expect_all("b2b_c4", 2'd2, 8'b0000_0010, 8'h00, 7'b0010000);
        tick;
        expect_all("b2b_c5", 2'd3, 8'h00, 8'b0000_0001, 7'b0001001);
        Run = 1'b0;
        tick;
        expect_all("b2b_c6", 2'd0, 8'h00, 8'h00, 7'b0000000);

        // reset during T2 of add R2,R3
        Run = 1'b1;
        DIN = {9'b010_010_011, 7'd0};
        expect_all("ra_t0", 2'd0, 8'h00, 8'h00, 7'b1000000);
        tick;
        Run = 1'b0;
        expect_all("ra_t1", 2'd1, 8'b0000_0100, 8'h00, 7'b0100000);
        tick;
        expect_all("ra_t2", 2'd2, 8'b0000_1000, 8'h00, 7'b0010000);
        Reset = 1'b1;
        expect_all("ra_rst", 2'd2, 8'h00, 8'h00, 7'b0000000);
        tick;
        Reset = 1'b0;
        expect_all("ra_after", 2'd0, 8'h00, 8'h00, 7'b0000000);
        tick;
        expect_all("ra_after2", 2'd0, 8'h00, 8'h00, 7'b0000000);
        Run = 1'b1;
        DIN = {9'b000_111_000, 7'd0};
        expect_all("ra_refetch", 2'd0, 8'h00, 8'h00, 7'b1000000);
        tick;
        Run = 1'b0;
        expect_all("ra_mv_t1", 2'd1, 8'b0000_0001, 8'b1000_0000, 7'b0000001);
        tick;

        // opcode 100, X=5 Y=6, Gnz low then high
        for (int g = 0; g < 2; g++) begin
            Gnz = g[0];
            Run = 1'b1;
            DIN = {9'b100_101_110, 7'd0};
            expect_all("op4_t0", 2'd0, 8'h00, 8'h00, 7'b1000000);
            tick;
            Run = 1'b0;
            expect_all("op4_t1", 2'd1, MVNZ_ROUT, (g == 1) ? MVNZ_RIN_GNZ : 8'h00, 7'b0000001);
            tick;
            expect_all("op4_end", 2'd0, 8'h00, 8'h00, 7'b0000000);
        end
        Gnz = 1'b0;

        // NOP opcodes 101, 110, 111 with Run held high
        Run = 1'b1;
        for (int k = 5; k < 8; k++) begin
            logic [2:0] opc;
            opc = 3'(k);
            DIN = {opc, 6'b111_111, 7'd0};
            expect_all("nop_t0", 2'd0, 8'h00, 8'h00, 7'b1000000);
            tick;
            expect_all("nop_t1", 2'd1, 8'h00, 8'h00, 7'b0000001);
            tick;
        end
        Run = 1'b0;
        expect_all("nop_end", 2'd0, 8'h00, 8'h00, 7'b0000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
